// File: rtl/popcount_pkg.sv
// Shared definitions for the population-counter subsystem.
// The length rule below sizes any field that must hold a count from 0 up to
// and including a word width. The packer uses it for its length output and the
// downstream population counter uses it for its result width.
package popcount_pkg;

   // Number of bits needed to represent every value in 0..w inclusive.
   function automatic int len_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_word_packer.sv
// Serial-to-parallel word packer.
// Gathers one bit per valid cycle into a WIDTH-bit word and presents each
// completed word with a single-cycle strobe. A flush request emits whatever
// has been gathered so far. The emitted word is zero-padded so a downstream
// population count stays exact, and the length field reports how many bits are
// real. Bit order within the word is chosen at elaboration time by MSB_FIRST.
module serial_word_packer
   import popcount_pkg::*;
#(
   parameter int WIDTH     = 24,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        srst_i,
   input  logic                        data_i,
   input  logic                        data_val_i,
   input  logic                        flush_i,
   output logic [WIDTH-1:0]            data_o,
   output logic                        data_val_o,
   output logic [len_width(WIDTH)-1:0] data_len_o,
   output logic                        busy_o
);

   localparam int LenW = len_width(WIDTH);
   localparam int CntW = $clog2(WIDTH);

   logic [WIDTH-1:0] shiftReg;
   logic [WIDTH-1:0] shiftNext;
   logic [WIDTH-1:0] flushWord;
   logic [CntW-1:0]  bitCount;
   logic [LenW-1:0]  heldCount;
   logic             wordDone;
   logic             flushNow;

   // Work out what this edge will do. heldCount is the number of bits the
   // partial word will hold once any bit arriving this cycle is included. That
   // is the figure a flush must report. A bit that completes the word takes
   // priority, so a flush arriving together with it is simply absorbed and
   // produces no extra empty word.
   always_comb begin
      heldCount = LenW'(bitCount) + LenW'(data_val_i);
      wordDone  = data_val_i && (bitCount == CntW'(WIDTH - 1));
      flushNow  = flush_i && (heldCount != '0) && !wordDone;
   end

   generate
      if (MSB_FIRST) begin : genMsbFirst
         // In MSB-first mode, bits shift in at the bottom. The first bit
         // therefore reaches the top position once the word is full. A partial
         // word still sits in the low bits, so a flush shifts it up to
         // left-align it and fill the vacated low bits with zeros. The valid
         // bit gates the shift, so an unknown data_i on idle cycles never
         // reaches the register.
         always_comb begin
            shiftNext = data_val_i ? {shiftReg[WIDTH-2:0], data_i} : shiftReg;
            flushWord = shiftNext << (LenW'(WIDTH) - heldCount);
         end
      end else begin : genLsbFirst
         // In LSB-first mode, each bit is written straight into the slot given
         // by the running count. A partial word is therefore already
         // right-aligned. Its upper bits are still zero from the last clear, so
         // the flush word is the register content as it stands.
         always_comb begin
            shiftNext = shiftReg;
            if (data_val_i) begin
               shiftNext[bitCount] = data_i;
            end
            flushWord = shiftNext;
         end
      end
   endgenerate

   // Register the packer state and the output word. The strobe drops back to
   // zero on every cycle unless a word is emitted. The word and length fields
   // keep their last value between strobes, because downstream only looks at
   // them on a strobe. Emitting a word, full or flushed, clears the partial
   // word so the next bit starts a fresh one. Reset discards any partial word
   // without emitting it.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         shiftReg   <= '0;
         bitCount   <= '0;
         data_o     <= '0;
         data_val_o <= 1'b0;
         data_len_o <= '0;
         busy_o     <= 1'b0;
      end else begin
         data_val_o <= 1'b0;
         if (wordDone) begin
            data_o     <= shiftNext;
            data_len_o <= LenW'(WIDTH);
            data_val_o <= 1'b1;
            shiftReg   <= '0;
            bitCount   <= '0;
            busy_o     <= 1'b0;
         end else if (flushNow) begin
            data_o     <= flushWord;
            data_len_o <= heldCount;
            data_val_o <= 1'b1;
            shiftReg   <= '0;
            bitCount   <= '0;
            busy_o     <= 1'b0;
         end else begin
            shiftReg <= shiftNext;
            if (data_val_i) begin
               bitCount <= bitCount + CntW'(1);
            end
            busy_o <= (heldCount != '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_word_packer.sv
// Self-checking bench for serial_word_packer.
// Two instances share one input stream, one packing MSB-first and one
// LSB-first. A reference model holds the pending bits in a queue and builds
// the expected words with plain position arithmetic.
module tb_serial_word_packer;

   localparam int W  = 24;
   localparam int LW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          srst;
   logic          dIn;
   logic          dVal;
   logic          flush;

   logic [W-1:0]  dataM, dataL;
   logic          valM, valL;
   logic [LW-1:0] lenM, lenL;
   logic          busyM, busyL;

   int            checks = 0;
   int            errors = 0;
   int            cycle  = 0;
   int            modelWords = 0;

   bit            heldBits[$];
   logic [W-1:0]  expWordM = '0;
   logic [W-1:0]  expWordL = '0;
   int            expLen   = 0;
   logic          expVal   = 1'b0;
   logic          expBusy  = 1'b0;
   int            pulseCycles[$];

   serial_word_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
      .clk_i(clk), .srst_i(srst), .data_i(dIn), .data_val_i(dVal), .flush_i(flush),
      .data_o(dataM), .data_val_o(valM), .data_len_o(lenM), .busy_o(busyM)
   );

   serial_word_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
      .clk_i(clk), .srst_i(srst), .data_i(dIn), .data_val_i(dVal), .flush_i(flush),
      .data_o(dataL), .data_val_o(valL), .data_len_o(lenL), .busy_o(busyL)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Perform one counted comparison and report a failure with its tag.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the reference model by one clock cycle. The model works from the
   // packing rules: it appends a valid bit to the queue. It emits a word when
   // the queue reaches W bits, or when a flush arrives and the queue holds
   // bits. The i-th received bit goes to position W-1-i in MSB-first order and
   // to position i in LSB-first order. Unfilled positions stay zero.
   task automatic modelStep(input logic v, input logic b, input logic f);
      expVal = 1'b0;
      if (v) heldBits.push_back(b);
      if (heldBits.size() == W || (f && heldBits.size() > 0)) begin
         expWordM = '0;
         expWordL = '0;
         for (int i = 0; i < heldBits.size(); i++) begin
            expWordM[W-1-i] = heldBits[i];
            expWordL[i]     = heldBits[i];
         end
         expLen = heldBits.size();
         expVal = 1'b1;
         modelWords++;
         heldBits.delete();
      end
      expBusy = (heldBits.size() != 0);
   endtask

   // Compare every output of both instances against the model. The word and
   // length fields are compared on every cycle, which also checks that they
   // hold their value between strobes and never pick up an X.
   task automatic checkOutput();
      if (valM === 1'b1) pulseCycles.push_back(cycle);
      checkValue("msb valid", valM, expVal);
      checkValue("msb data",  dataM, expWordM);
      checkValue("msb len",   lenM, expLen);
      checkValue("msb busy",  busyM, expBusy);
      checkValue("lsb valid", valL, expVal);
      checkValue("lsb data",  dataL, expWordL);
      checkValue("lsb len",   lenL, expLen);
      checkValue("lsb busy",  busyL, expBusy);
   endtask

   // Drive one cycle of inputs, wait for the clock edge, then compare the
   // outputs against the model. data_i is driven to X on idle cycles.
   task automatic applyStimulus(input logic v, input logic b, input logic f);
      dVal  = v;
      dIn   = v ? b : 1'bx;
      flush = f;
      @(posedge clk);
      #1;
      cycle++;
      modelStep(v, b, f);
      checkOutput();
      dVal  = 1'b0;
      dIn   = 1'bx;
      flush = 1'b0;
   endtask

   initial begin
      logic [W-1:0] pattern;
      logic         r;

      srst  = 1'b1;
      dVal  = 1'b0;
      dIn   = 1'bx;
      flush = 1'b0;
      #12;
      $display("[TB] reset state");
      checkOutput();
      @(negedge clk);
      srst = 1'b0;

      // Full word 0xA5A5A5, MSB-first, at the full bit rate.
      $display("[TB] single full word");
      pattern = 24'hA5A5A5;
      for (int i = W - 1; i >= 0; i--) applyStimulus(1'b1, pattern[i], 1'b0);
      checkValue("a5 word", dataM, 24'hA5A5A5);
      checkValue("a5 len", lenM, 32'd24);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Two words back-to-back must strobe exactly W cycles apart.
      $display("[TB] back-to-back words");
      pulseCycles.delete();
      pattern = 24'hFFFFFF;
      for (int i = W - 1; i >= 0; i--) applyStimulus(1'b1, pattern[i], 1'b0);
      pattern = 24'h000001;
      for (int i = W - 1; i >= 0; i--) applyStimulus(1'b1, pattern[i], 1'b0);
      checkValue("b2b last word", dataM, 24'h000001);
      checkValue("b2b pulse count", pulseCycles.size(), 32'd2);
      if (pulseCycles.size() >= 2)
         checkValue("b2b pulse gap", pulseCycles[1] - pulseCycles[0], 32'd24);

      // Five bits, then a flush on its own.
      $display("[TB] partial flush");
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkValue("flush msb word", dataM, 24'hB80000);
      checkValue("flush lsb word", dataL, 24'h00001D);
      checkValue("flush len", lenM, 32'd5);

      // A flush arriving with the word-completing bit gives a single full word.
      $display("[TB] flush with last bit");
      pulseCycles.delete();
      for (int i = 0; i < W - 1; i++) applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkValue("absorbed flush pulses", pulseCycles.size(), 32'd1);
      checkValue("absorbed flush len", lenM, 32'd24);

      // A flush while the packer is empty produces nothing.
      $display("[TB] flush while empty");
      pulseCycles.delete();
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkValue("empty flush pulses", pulseCycles.size(), 32'd0);

      // Assert reset between edges after 10 bits. Outputs must clear at once,
      // and the partial word must be lost.
      $display("[TB] async reset mid-word");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      #2;
      srst = 1'b1;
      #1;
      heldBits.delete();
      expWordM = '0;
      expWordL = '0;
      expLen   = 0;
      expVal   = 1'b0;
      expBusy  = 1'b0;
      checkOutput();
      @(negedge clk);
      srst = 1'b0;
      pulseCycles.delete();
      for (int i = 0; i < W; i++) applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0);
      checkValue("post reset pulses", pulseCycles.size(), 32'd1);

      // Random traffic: about 30% idle cycles and occasional flushes,
      // run until the model has emitted 1000 more words.
      $display("[TB] random traffic");
      modelWords = 0;
      while (modelWords < 1000 && cycle < 90000) begin
         r = 1'($urandom_range(1));
         applyStimulus(($urandom_range(99) >= 30), r, ($urandom_range(199) == 0));
      end
      checkValue("random word count", modelWords, 32'd1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_word_packer.md
Name: serial_word_packer

Overview:
- Collects a serial bitstream into WIDTH-bit parallel words and presents each word with a one-cycle valid strobe.
- Sits directly upstream of the bit population counter; its data_o/data_val_o connect straight to that stage's data_i/data_val_i.
- A flush request emits a partially filled word, zero-padded, so the population count of a partial word stays exact.

Parameters:
- WIDTH, 24, output word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 means the first received bit lands in data_o[WIDTH-1]; 0 means it lands in data_o[0].

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  reset, asynchronous, active-high.
- data_i  input  1  serial data bit.
- data_val_i  input  1  data_i valid this cycle.
- flush_i  input  1  single-cycle request to emit the current partial word.
- data_o  output  WIDTH  packed word, registered.
- data_val_o  output  1  one-cycle strobe; data_o and data_len_o are valid while it is high.
- data_len_o  output  $clog2(WIDTH+1)  number of real bits in data_o (1..WIDTH).
- busy_o  output  1  high while the partial word holds at least one bit.

Behaviour:
- Reset (async assert, released synchronously to clk_i):
  - data_o = 0, data_val_o = 0, data_len_o = 0, busy_o = 0.
  - Bit counter = 0; shift register = 0.
  - Reset mid-word discards the partial word; no output is produced for it.
- Internal state:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1.
  - No explicit FSM; the states are EMPTY (cnt=0) and FILLING (cnt>0).
- Bit accept:
  - A bit is accepted on every rising edge with data_val_i=1; there is no backpressure.
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], data_i}.
  - MSB_FIRST=0: the bit is written at position cnt.
  - cnt increments by 1.
- Word complete:
  - When the accepted bit is the WIDTH-th bit (cnt==WIDTH-1 with data_val_i=1), on the same edge:
    - data_o <= completed word; data_len_o <= WIDTH; data_val_o <= 1.
    - cnt <= 0; sr <= 0.
  - Latency: data_val_o is high in the cycle right after the edge that accepted the last bit (1 cycle).
- Flush:
  - flush_i=1 with cnt>0 (counting the bit accepted in the same cycle, if any):
    - Emit the partial word next cycle; data_len_o = number of bits held.
    - MSB_FIRST=1: the held bits are left-aligned and the low bits are zero.
    - MSB_FIRST=0: the held bits are right-aligned and the high bits are zero.
    - cnt and sr are cleared.
  - flush_i with cnt==0 and data_val_i=0: no output, no state change.
- Simultaneous data_val_i and flush_i:
  - The bit is accepted first, then the flush applies.
  - If that bit completes the word, exactly one full word (len WIDTH) is emitted; the flush is absorbed and produces no extra empty output.
- data_val_o:
  - High for exactly one cycle per emitted word; never high on two consecutive cycles with fewer than WIDTH accepted bits between them, except after a flush.
  - Back-to-back full words at the full bit rate give data_val_o high one cycle in every WIDTH.
- data_o and data_len_o:
  - Hold their last value while data_val_o=0.
  - Downstream must only sample them on data_val_o.
- busy_o = (cnt != 0), registered.
- X on data_i while data_val_i=0 must not propagate into sr.

Decomposition:
- Shared package (named for the population-counter subsystem): function len_width(w) returning $clog2(w+1). The same width rule is used for popcount result sizing, so the downstream stage can adopt it.
- No sub-module; the shift register and counter live in one module, with a generate branch on MSB_FIRST.

Test Plan:
- WIDTH=24, MSB_FIRST=1: stream 24 valid bits 0xA5A5A5 MSB-first, continuously -> one data_val_o pulse 1 cycle after the 24th bit; data_o=0xA5A5A5, data_len_o=24, busy_o returns to 0.
- 48 bits back-to-back (0xFFFFFF then 0x000001) -> two pulses exactly 24 cycles apart with those values; no lost or duplicated bits.
- 5 bits 1,0,1,1,1 then flush_i alone -> data_o=0xB80000, data_len_o=5. Repeat with MSB_FIRST=0 -> data_o=0x00001D.
- flush_i together with the 24th valid bit -> a single pulse, len 24; no second pulse on the following cycles. flush_i while empty -> no pulse.
- Random gaps in data_val_i (about 30% idle) over 1000 words -> every output matches the reference model; X driven on data_i while invalid causes no X on data_o.
- Assert srst_i asynchronously mid-edge after 10 bits, then send 24 new bits -> all outputs 0 immediately on assert; the first pulse after release carries only the new 24 bits.
